// File: rtl/uart_pkg.sv
// Shared constants for the UART receive and transmit paths: state codes,
// oversampling positions and the parity helper.
package uart_pkg;

    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        START  = 4'd1,
        DATA   = 4'd2,
        PARITY = 4'd3,
        STOP   = 4'd4
    } rx_state_e;

    localparam int OVERSAMPLE = 16;
    localparam int SAMPLE_LO  = 7;
    localparam int SAMPLE_MID = 8;
    localparam int SAMPLE_HI  = 9;
    localparam int DATA_BITS  = 8;

    function automatic logic parity_bit(input logic [DATA_BITS-1:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick divider: pulses tick once every CLKS_PER_TICK cycles,
// restarting from zero whenever clr is high.
module uart_baud_tick #(
    parameter int CLKS_PER_TICK = 4
) (
    input  logic clka,
    input  logic reset,
    input  logic clr,
    output logic tick
);
    localparam int CW = (CLKS_PER_TICK > 1) ? $clog2(CLKS_PER_TICK) : 1;

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        tick = !clr && (cnt_q == CW'(CLKS_PER_TICK - 1));
        if (clr || tick) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clka) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_serial_rx.sv
// 16x-oversampled UART receiver with majority voting, single-entry holding
// register (valid/ack) and per-frame error flags.
module uart_serial_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_TICK = 4,
    parameter bit PARITY_EN     = 1'b1,
    parameter bit PARITY_ODD    = 1'b0
) (
    input  logic       clka,
    input  logic       reset,
    input  logic       rxd,
    input  logic       rx_ack,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_frame_err,
    output logic       rx_parity_err,
    output logic       rx_overrun,
    output logic       rx_busy,
    output logic [3:0] rstate
);
    localparam logic [3:0] S_LO   = 4'(SAMPLE_LO);
    localparam logic [3:0] S_MID  = 4'(SAMPLE_MID);
    localparam logic [3:0] S_HI   = 4'(SAMPLE_HI);
    localparam logic [3:0] S_LAST = 4'(OVERSAMPLE - 1);

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    rx_state_e state_q, state_d;
    logic [3:0] s_q, s_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [1:0] smp_q, smp_d;
    logic [7:0] shift_q, shift_d;
    logic       perr_q, perr_d;
    logic       rxs1_q, rxs1_d, rxs_q, rxs_d, rxs_prev_q, rxs_prev_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       rx_valid_q, rx_valid_d;
    logic       rx_ferr_q, rx_ferr_d;
    logic       rx_perr_q, rx_perr_d;
    logic       rx_ovr_q, rx_ovr_d;
    logic       tick, maj, commit, ferr_new;

    uart_baud_tick #(.CLKS_PER_TICK(CLKS_PER_TICK)) u_tick (
        .clka  (clka),
        .reset (reset),
        .clr   (state_q == IDLE),
        .tick  (tick)
    );

    always_comb begin
        state_d    = state_q;
        s_d        = s_q;
        bit_cnt_d  = bit_cnt_q;
        smp_d      = smp_q;
        shift_d    = shift_q;
        perr_d     = perr_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = rx_valid_q;
        rx_ferr_d  = rx_ferr_q;
        rx_perr_d  = rx_perr_q;
        rx_ovr_d   = rx_ovr_q;
        rxs1_d     = rxd;
        rxs_d      = rxs1_q;
        rxs_prev_d = rxs_q;
        commit     = 1'b0;
        ferr_new   = 1'b0;
        maj        = majority3(smp_q[0], smp_q[1], rxs_q);

        if (state_q == IDLE) begin
            s_d = '0;
            if (rxs_prev_q && !rxs_q) begin
                state_d   = START;
                bit_cnt_d = '0;
                perr_d    = 1'b0;
            end
        end else if (tick) begin
            s_d = s_q + 4'd1;
            if (s_q == S_LO)  smp_d[0] = rxs_q;
            if (s_q == S_MID) smp_d[1] = rxs_q;
            case (state_q)
                START: begin
                    if (s_q == S_HI && maj) begin
                        state_d = IDLE;
                    end else if (s_q == S_LAST) begin
                        state_d = DATA;
                    end
                end
                DATA: begin
                    if (s_q == S_HI) shift_d = {maj, shift_q[7:1]};
                    if (s_q == S_LAST) begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'(DATA_BITS - 1)) begin
                            if (PARITY_EN) state_d = PARITY;
                            else           state_d = STOP;
                        end
                    end
                end
                PARITY: begin
                    if (s_q == S_HI && maj != parity_bit(shift_q, PARITY_ODD)) perr_d = 1'b1;
                    if (s_q == S_LAST) state_d = STOP;
                end
                STOP: begin
                    // Stop is judged mid-bit so the next start edge is not missed.
                    if (s_q == S_HI) begin
                        commit   = 1'b1;
                        ferr_new = !maj;
                        state_d  = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        if (commit && (!rx_valid_q || rx_ack)) begin
            rx_data_d  = shift_q;
            rx_ferr_d  = ferr_new;
            rx_perr_d  = perr_q;
            rx_valid_d = 1'b1;
            rx_ovr_d   = 1'b0;
        end else if (commit) begin
            rx_ovr_d = 1'b1;
        end else if (rx_ack && rx_valid_q) begin
            rx_valid_d = 1'b0;
            rx_ovr_d   = 1'b0;
        end
    end

    always_ff @(posedge clka) begin
        if (reset) begin
            state_q    <= IDLE;
            s_q        <= '0;
            bit_cnt_q  <= '0;
            perr_q     <= 1'b0;
            rxs1_q     <= 1'b1;
            rxs_q      <= 1'b1;
            rxs_prev_q <= 1'b1;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            rx_ferr_q  <= 1'b0;
            rx_perr_q  <= 1'b0;
            rx_ovr_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            s_q        <= s_d;
            bit_cnt_q  <= bit_cnt_d;
            perr_q     <= perr_d;
            rxs1_q     <= rxs1_d;
            rxs_q      <= rxs_d;
            rxs_prev_q <= rxs_prev_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            rx_ferr_q  <= rx_ferr_d;
            rx_perr_q  <= rx_perr_d;
            rx_ovr_q   <= rx_ovr_d;
        end
        smp_q   <= smp_d;
        shift_q <= shift_d;
    end

    assign rx_data       = rx_data_q;
    assign rx_valid      = rx_valid_q;
    assign rx_frame_err  = rx_ferr_q;
    assign rx_parity_err = rx_perr_q;
    assign rx_overrun    = rx_ovr_q;
    assign rx_busy       = (state_q != IDLE);
    assign rstate        = state_q;

endmodule

// File: tb/tb_uart_serial_rx.sv
// Bench for uart_serial_rx: even- and odd-parity receivers share one line and
// are checked against a frame-level model of the holding register.
module tb_uart_serial_rx;
    localparam int C        = 4;
    localparam int BIT_CLKS = 16 * C;
    localparam int LAT      = 3 + C * ((9 + 1) * 16 + 10);

    logic       clka = 1'b0, reset = 1'b1, rxd = 1'b1, rx_ack = 1'b0;
    logic [7:0] e_data, o_data;
    logic       e_valid, e_ferr, e_perr, e_ovr, e_busy;
    logic       o_valid, o_ferr, o_perr, o_ovr, o_busy;
    logic [3:0] e_rstate, o_rstate;

    uart_serial_rx #(.CLKS_PER_TICK(C), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)) dut_even (
        .clka(clka), .reset(reset), .rxd(rxd), .rx_ack(rx_ack),
        .rx_data(e_data), .rx_valid(e_valid), .rx_frame_err(e_ferr),
        .rx_parity_err(e_perr), .rx_overrun(e_ovr), .rx_busy(e_busy), .rstate(e_rstate)
    );

    uart_serial_rx #(.CLKS_PER_TICK(C), .PARITY_EN(1'b1), .PARITY_ODD(1'b1)) dut_odd (
        .clka(clka), .reset(reset), .rxd(rxd), .rx_ack(rx_ack),
        .rx_data(o_data), .rx_valid(o_valid), .rx_frame_err(o_ferr),
        .rx_parity_err(o_perr), .rx_overrun(o_ovr), .rx_busy(o_busy), .rstate(o_rstate)
    );

    always #5 clka = ~clka;

    int cyc = 0;
    always @(posedge clka) cyc <= cyc + 1;

    int frame_start = 0;
    int rise_cyc    = -1;
    always @(negedge clka) begin : rise_mon
        logic prev_v;
        if (e_valid && !prev_v) rise_cyc = cyc;
        prev_v = e_valid;
    end

    int tests = 0, fails = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Frame-level model of the holding register
    logic [7:0] m_data = 8'h00;
    logic       m_valid = 1'b0, m_ferr = 1'b0, m_perr_e = 1'b0, m_perr_o = 1'b0, m_ovr = 1'b0;

    task automatic model_frame(input logic [7:0] d, input logic p, input logic stop, input logic ack);
        if (!m_valid || ack) begin
            m_data   = d;
            m_ferr   = !stop;
            m_perr_e = (p != (^d));
            m_perr_o = (p != !(^d));
            m_valid  = 1'b1;
            m_ovr    = 1'b0;
        end else begin
            m_ovr = 1'b1;
        end
    endtask

    task automatic model_ack();
        if (m_valid) begin
            m_valid = 1'b0;
            m_ovr   = 1'b0;
        end
    endtask

    task automatic check_model(input string tag);
        check_eq({tag, ".data"},  32'(e_data),  32'(m_data));
        check_eq({tag, ".valid"}, 32'(e_valid), 32'(m_valid));
        check_eq({tag, ".ferr"},  32'(e_ferr),  32'(m_ferr));
        check_eq({tag, ".perr"},  32'(e_perr),  32'(m_perr_e));
        check_eq({tag, ".ovr"},   32'(e_ovr),   32'(m_ovr));
        check_eq({tag, ".odata"}, 32'(o_data),  32'(m_data));
        check_eq({tag, ".ovalid"},32'(o_valid), 32'(m_valid));
        check_eq({tag, ".oferr"}, 32'(o_ferr),  32'(m_ferr));
        check_eq({tag, ".operr"}, 32'(o_perr),  32'(m_perr_o));
        check_eq({tag, ".oovr"},  32'(o_ovr),   32'(m_ovr));
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, ".data"},   32'(e_data),   0);
        check_eq({tag, ".flags"},  32'({e_valid, e_ferr, e_perr, e_ovr, e_busy}), 0);
        check_eq({tag, ".rstate"}, 32'(e_rstate), 0);
        check_eq({tag, ".odd"},    32'({o_data, o_valid, o_ferr, o_perr, o_ovr, o_busy, o_rstate}), 0);
    endtask

    // Called just after a rising edge; returns just after a rising edge.
    task automatic send_frame(input logic [7:0] d, input logic p, input logic stop, input int nbits);
        logic [10:0] bits;
        bits = {stop, p, d, 1'b0};
        frame_start = cyc;
        for (int i = 0; i < nbits; i++) begin
            rxd = bits[i];
            repeat (BIT_CLKS) @(posedge clka);
            #1;
        end
    endtask

    task automatic idle(input int n);
        rxd = 1'b1;
        repeat (n) @(posedge clka);
        #1;
    endtask

    task automatic pulse_ack();
        rx_ack = 1'b1;
        @(posedge clka);
        #1;
        rx_ack = 1'b0;
        model_ack();
    endtask

    initial begin
        repeat (3) @(posedge clka);
        #1;
        check_all_zero("reset");
        reset = 1'b0;
        idle(5);

        // Clean frame with exact latency, then ack
        rise_cyc = -1;
        send_frame(8'hA5, 1'b0, 1'b1, 11);
        model_frame(8'hA5, 1'b0, 1'b1, 1'b0);
        check_eq("a5.latency", 32'(rise_cyc - frame_start), 32'(LAT));
        check_model("a5");
        pulse_ack();
        check_model("a5.ack");

        // Wrong even parity (correct odd parity)
        send_frame(8'h3C, 1'b1, 1'b1, 11);
        model_frame(8'h3C, 1'b1, 1'b1, 1'b0);
        check_model("3c");
        pulse_ack();

        // Framing error, then a good frame clears the flag
        send_frame(8'h5A, 1'b0, 1'b0, 11);
        idle(BIT_CLKS);
        model_frame(8'h5A, 1'b0, 1'b0, 1'b0);
        check_model("5a.ferr");
        pulse_ack();
        send_frame(8'h01, 1'b1, 1'b1, 11);
        model_frame(8'h01, 1'b1, 1'b1, 1'b0);
        check_model("01");
        pulse_ack();

        // Short low glitch is a false start
        rxd = 1'b0;
        repeat (16) @(posedge clka);
        #1;
        check_eq("glitch.busy", 32'(e_busy), 1);
        check_eq("glitch.rstate", 32'(e_rstate), 1);
        idle(2 * BIT_CLKS);
        check_eq("glitch.idle", 32'({e_busy, e_rstate}), 0);
        check_model("glitch");
        send_frame(8'h7E, 1'b0, 1'b1, 11);
        model_frame(8'h7E, 1'b0, 1'b1, 1'b0);
        check_model("7e");
        pulse_ack();

        // Back-to-back without ack: first byte kept, overrun set
        send_frame(8'h11, 1'b0, 1'b1, 11);
        send_frame(8'h22, 1'b0, 1'b1, 11);
        model_frame(8'h11, 1'b0, 1'b1, 1'b0);
        model_frame(8'h22, 1'b0, 1'b1, 1'b0);
        check_model("b2b.noack");
        pulse_ack();
        check_model("b2b.ack");

        // Back-to-back with ack exactly in the commit cycle of the second frame
        fork
            begin
                send_frame(8'h11, 1'b0, 1'b1, 11);
                send_frame(8'h22, 1'b0, 1'b1, 11);
            end
            begin
                repeat (11 * BIT_CLKS + LAT - 1) @(posedge clka);
                #1 rx_ack = 1'b1;
                @(posedge clka);
                #1 rx_ack = 1'b0;
            end
        join
        model_frame(8'h11, 1'b0, 1'b1, 1'b0);
        model_frame(8'h22, 1'b0, 1'b1, 1'b1);
        check_model("b2b.commitack");

        // Reset in the middle of a frame while a byte is held
        send_frame(8'hFF, 1'b0, 1'b1, 4);
        check_eq("rst.indata", 32'(e_rstate), 2);
        rxd   = 1'b1;
        reset = 1'b1;
        @(posedge clka);
        #1;
        check_all_zero("rst.mid");
        reset   = 1'b0;
        m_valid = 1'b0; m_data = 8'h00; m_ferr = 1'b0; m_perr_e = 1'b0; m_perr_o = 1'b0; m_ovr = 1'b0;
        idle(BIT_CLKS);
        send_frame(8'hC3, 1'b0, 1'b1, 11);
        model_frame(8'hC3, 1'b0, 1'b1, 1'b0);
        check_model("c3");
        pulse_ack();

        // Randomized frames with random errors and occasionally skipped acks
        for (int n = 0; n < 24; n++) begin
            logic [7:0] d;
            logic       p, stop;
            d    = 8'($urandom);
            p    = (^d) ^ ($urandom_range(0, 3) == 0);
            stop = ($urandom_range(0, 3) != 0);
            send_frame(d, p, stop, 11);
            model_frame(d, p, stop, 1'b0);
            check_model($sformatf("rnd%0d", n));
            idle(BIT_CLKS / 2 + int'($urandom_range(0, 20)));
            if ($urandom_range(0, 2) != 0) pulse_ack();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_serial_rx.md
Name: uart_serial_rx

Overview:
Serial-line UART receiver, the far-end counterpart of the team's UART transmit path. Takes an asynchronous 1-bit line (8 data bits LSB-first, optional parity, 1 stop bit) and oversamples it 16x with majority voting. Delivers each byte through a single-entry holding register with a valid/ack handshake, plus per-frame error flags.

Parameters:
CLKS_PER_TICK, 4, clka cycles per oversample tick (>=1); baud = f_clka / (CLKS_PER_TICK*16)
PARITY_EN, 1, 1 = parity bit present between data and stop
PARITY_ODD, 0, 0 = even parity, 1 = odd parity (ignored when PARITY_EN=0)

Ports:
clka  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
rxd  in  1  asynchronous serial line, idle high
rx_ack  in  1  consumer accepts the held byte when rx_valid=1
rx_data  out  8  received byte (holding register)
rx_valid  out  1  holding register full
rx_frame_err  out  1  stop bit sampled low for the held byte
rx_parity_err  out  1  parity mismatch for the held byte
rx_overrun  out  1  sticky: a frame completed while rx_valid=1 with no ack
rx_busy  out  1  1 whenever rstate != IDLE
rstate  out  4  debug state code (IDLE=0, START=1, DATA=2, PARITY=3, STOP=4)

Behaviour:
- Clock and reset: one clock, clka. reset is synchronous and active-high. In the reset cycle all outputs go to 0, rstate goes to IDLE, both sync flops and the edge-detect flop load 1, and the tick divider and sample counters clear. Reset mid-frame discards the partial frame silently.
- Synchronizer: rxd passes through 2 flops (rxs). Start detect = previous rxs 1 and current rxs 0. A line held low (break) therefore arms only one start.
- Tick: divider counts 0..CLKS_PER_TICK-1 and pulses tick on the terminal count. Divider and sample index s (0..15) both clear on the start-detect cycle, so the first tick lands CLKS_PER_TICK cycles later.
- Bit timing: each bit spans 16 ticks, s=0..15. rxs is sampled on the ticks where s=7, 8 and 9. The bit value is the majority of those 3 samples, decided at the s=9 tick. The state advances at the s=15 tick, and s wraps to 0.
- IDLE -> START on start detect.
- START: majority 1 at s=9 means a false start; return to IDLE immediately with no flags and no output. Majority 0 -> DATA at s=15.
- DATA: bit shifts into shift[7] with a right shift, so the result is LSB-first. A 3-bit counter runs 0..7. After bit 7 at s=15 -> PARITY if PARITY_EN, else -> STOP.
- PARITY: expected bit = XOR(shift) XOR PARITY_ODD. A mismatch latches perr. -> STOP at s=15.
- STOP: decided at s=9 (half-bit early, which allows back-to-back frames). ferr = (majority == 0). Commit, then -> IDLE in the same cycle.
- Commit, when rx_valid=0 or rx_ack=1 in the commit cycle:
  - rx_data <= shift; rx_frame_err <= ferr; rx_parity_err <= perr; rx_valid <= 1 on the next edge.
  - Load wins over a simultaneous ack.
- Commit when rx_valid=1 and rx_ack=0:
  - Holding register and flags are unchanged (old byte kept); the new frame is dropped.
  - rx_overrun <= 1.
- Ack: rx_ack while rx_valid=1 with no commit clears rx_valid on the next edge. Error flags hold their values until the next load. rx_overrun clears on the first accepted ack. rx_ack while rx_valid=0 is ignored.
- Latency: rx_valid rises 1 cycle after the STOP s=9 tick. Measured from the rxd falling edge that is 2 sync + 1 detect + ((9+PARITY_EN)*16 + 10)*CLKS_PER_TICK cycles.
- rx_busy = (rstate != IDLE). No combinational path from rxd or rx_ack to any output.

Decomposition:
- Shared package uart_pkg: state encoding constants (IDLE..STOP, 4-bit), OVERSAMPLE=16, SAMPLE_LO/MID/HI = 7/8/9, DATA_BITS=8, and a parity function.
- One sub-module, uart_baud_tick: divider with clear input and tick output, reused by the transmit side.
- FSM, shift register and holding register stay in uart_serial_rx.

Test Plan:
- Parameters CLKS_PER_TICK=4, even parity. Drive frame 0xA5, parity 0, stop 1 -> rx_data=0xA5, rx_valid=1 exactly at the latency above, both error flags 0. Ack -> rx_valid=0 next cycle.
- Frame 0x3C with parity bit 1 -> rx_data=0x3C, rx_parity_err=1, rx_frame_err=0. Repeat with PARITY_ODD=1 -> rx_parity_err=0.
- Frame 0x5A with stop bit 0, then line high -> rx_data=0x5A, rx_frame_err=1. Next good frame 0x01 -> rx_frame_err clears to 0.
- rxd low for 16 clka cycles (4 ticks), then high -> returns to IDLE, rx_valid stays 0, no flags. A following frame 0x7E is received correctly.
- Back-to-back frames 0x11, 0x22 with no ack -> rx_data=0x11, rx_overrun=1. Ack -> rx_valid=0, rx_overrun=0. Ack in the commit cycle of 0x22 instead -> rx_data=0x22, rx_valid=1, rx_overrun=0.
- Assert reset in the DATA state of frame 0xFF -> next cycle all outputs 0, rstate=0. A frame 0xC3 sent after reset is received with no errors.
